// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester-side handshake signals and the single RAM port they share.
// The arbiter takes the slave view; the surrounding datapath or bench takes the master view.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0]         ram_address;
  logic                      ram_wren;
  logic [DATA_W-1:0]         ram_data;
  logic [DATA_W-1:0]         ram_q;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      idle;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_q,
    output req_ready, ram_address, ram_wren, ram_data, rsp_valid, rsp_data, idle
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_q,
    input  req_ready, ram_address, ram_wren, ram_data, rsp_valid, rsp_data, idle
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with a
// LATENCY-deep tag pipeline that steers read data back to the issuing requester.
module ram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   bus
);
  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    ptr_next;
  logic [LATENCY-1:0] pipe_valid_reg;
  logic [ID_W-1:0]    pipe_id_reg [LATENCY];

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [ID_W-1:0]    cand_idx  [NUM_REQ];
  logic [NUM_REQ-1:0] cand_valid;
  logic               found;
  logic               grant;
  logic [ID_W-1:0]    win;

  // Candidate gi is the requester gi places after the pointer, wrapped modulo NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign addr_arr[gi]   = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]  = bus.req_wdata[gi*DATA_W +: DATA_W];
      assign sum            = {1'b0, ptr_reg} + (ID_W+1)'(gi);
      assign cand_idx[gi]   = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                          : sum[ID_W-1:0];
      assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the candidate closest to the pointer is written last and wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        found = 1'b1;
        win   = cand_idx[k];
      end
    end
  end

  assign grant = found & ~reset;

  always_comb begin
    bus.req_ready   = '0;
    bus.ram_address = '0;
    bus.ram_data    = '0;
    bus.ram_wren    = 1'b0;
    ptr_next        = ptr_reg;
    if (grant) begin
      bus.req_ready[win] = 1'b1;
      bus.ram_address    = addr_arr[win];
      bus.ram_data       = wdata_arr[win];
      bus.ram_wren       = bus.req_we[win];
      ptr_next           = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Only granted reads enter the tag pipeline; the id stages need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg        <= '0;
      pipe_valid_reg <= '0;
    end else begin
      ptr_reg           <= ptr_next;
      pipe_valid_reg[0] <= grant & ~bus.ram_wren;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
      end
    end
    pipe_id_reg[0] <= win;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_id_reg[k] <= pipe_id_reg[k-1];
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (pipe_valid_reg[LATENCY-1] && !reset) begin
      bus.rsp_valid[pipe_id_reg[LATENCY-1]] = 1'b1;
    end
  end

  assign bus.rsp_data = bus.ram_q;
  assign bus.idle     = reset | (~|bus.req_valid & ~|pipe_valid_reg);

endmodule
